// File: rtl/instr_fetch_if.sv
// instr_fetch_if: instruction-memory port, decode handshake and control lines of the fetch sequencer
interface instr_fetch_if #(parameter int ADDR_W = 16);
  logic [ADDR_W-1:0] imem_pc;
  logic [15:0]       imem_instr;
  logic              f_valid;
  logic              f_ready;
  logic [15:0]       f_instr;
  logic [ADDR_W-1:0] f_pc;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              halt;
  logic              resume;
  logic [1:0]        state;
  logic              fault;
  modport master (
    output imem_pc, f_valid, f_instr, f_pc, state, fault,
    input  imem_instr, f_ready, redirect, redirect_pc, halt, resume
  );
  modport slave (
    input  imem_pc, f_valid, f_instr, f_pc, state, fault,
    output imem_instr, f_ready, redirect, redirect_pc, halt, resume
  );
endinterface

// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl: PC sequencer with one-entry fetch output register, redirect, halt/resume and range fault
module instr_fetch_ctrl #(
  parameter int                ADDR_W    = 16,
  parameter int                ROM_WORDS = 15,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input logic         clk,
  input logic         reset,
  instr_fetch_if.master bus
);
  typedef enum logic [1:0] {FETCH = 2'b00, HALTED = 2'b01, FAULT = 2'b10} state_t;
  state_t            st, st_d;
  logic [ADDR_W-1:0] pc, pc_d, fpc, fpc_d;
  logic [15:0]       fi, fi_d;
  logic              fv, fv_d;
  logic              legal, slot_free, take;
  assign legal     = !pc[0] && pc < ADDR_W'(2 * ROM_WORDS);
  assign slot_free = !fv || bus.f_ready;
  assign take      = fv && bus.f_ready;
  always_ff @(posedge clk) begin
    if (reset) begin
      st  <= FETCH;
      pc  <= RESET_PC;
      fv  <= 1'b0;
      fi  <= '0;
      fpc <= '0;
    end else begin
      st  <= st_d;
      pc  <= pc_d;
      fv  <= fv_d;
      fi  <= fi_d;
      fpc <= fpc_d;
    end
  end
  // A redirect overrides everything but reset; a held instruction is dropped even if accepted.
  always_comb begin
    st_d  = st;
    pc_d  = pc;
    fv_d  = fv;
    fi_d  = fi;
    fpc_d = fpc;
    if (bus.redirect) begin
      fv_d = 1'b0;
      pc_d = bus.redirect_pc;
      st_d = (st == HALTED) ? HALTED : FETCH;
    end else if (st == FETCH) begin
      if (bus.halt) begin
        st_d = HALTED;
        fv_d = take ? 1'b0 : fv;
      end else if (slot_free && legal) begin
        fv_d  = 1'b1;
        fi_d  = bus.imem_instr;
        fpc_d = pc;
        pc_d  = pc + ADDR_W'(2);
      end else if (slot_free) begin
        fv_d = 1'b0;
        st_d = FAULT;
      end
    end else if (st == HALTED) begin
      fv_d = take ? 1'b0 : fv;
      st_d = (!bus.halt && bus.resume) ? FETCH : HALTED;
    end else begin
      fv_d = 1'b0;
    end
  end
  assign bus.imem_pc = pc;
  assign bus.f_valid = fv;
  assign bus.f_instr = fi;
  assign bus.f_pc    = fpc;
  assign bus.state   = st;
  assign bus.fault   = (st == FAULT);
endmodule
